// File: rtl/fifo_reader.sv
// fifo_reader: pulls words from a show-ahead-less FIFO (data one cycle after
// READ) into a two-entry output buffer (output register + skid register) and
// presents them on a valid/ready stream. Flush clears the buffer and the FIFO.
//
// Optional feature: define FIFO_READER_COUNT_EN to build the 16-bit counter of
// accepted words on WORD_COUNT; without it WORD_COUNT is tied to zero.
//
// Handshake: a word moves downstream on every rising CLOCK edge where
// M_VALID=1 and M_READY=1. While M_VALID=1 and M_READY=0, M_VALID and M_DATA
// hold. M_VALID never depends combinationally on M_READY.
module fifo_reader #(
   parameter int size = 8,
   parameter int tam  = 32
) (
   input  logic                       CLOCK,
   input  logic                       RESET,
   input  logic                       ENABLE,
   input  logic                       FLUSH,
   input  logic                       F_EMPTY_N,
   input  logic [$clog2(tam-1)-1:0]   USE_DW,
   input  logic [size-1:0]            FIFO_DATA,
   output logic                       READ,
   output logic                       CLEAR_N,
   output logic [size-1:0]            M_DATA,
   output logic                       M_VALID,
   input  logic                       M_READY,
   output logic [15:0]                WORD_COUNT,
   output logic [1:0]                 STATE_DBG
);

   localparam int             DW       = $clog2(tam-1);
   localparam logic [DW-1:0]  ONE_WORD = DW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t            state;
   logic [size-1:0]   skid_data;
   logic              skid_valid;
   logic              in_flight;
   logic              xfer;
   logic [1:0]        fill;
   logic              last_in_flight;

   assign xfer = M_VALID & M_READY;

   // Occupancy once this cycle's transfer has left: buffered words plus the
   // word already on its way from the FIFO. A new read is safe only if this
   // is below 2, so the buffer can never be asked to hold a third word.
   assign fill = {1'b0, M_VALID} + {1'b0, skid_valid} + {1'b0, in_flight} - {1'b0, xfer};

   // The FIFO's flags lag the read by a cycle: with a word in flight and the
   // count still showing 1, that in-flight word is the last one.
   assign last_in_flight = in_flight & (USE_DW == ONE_WORD);

   // READ is decoded from registered state so the FIFO data lands exactly one
   // cycle later; a flush request blocks it so nothing is popped and lost.
   assign READ = (state == S_RUN) & ENABLE & ~FLUSH & F_EMPTY_N &
                 (fill < 2'd2) & ~last_in_flight;

   assign CLEAR_N   = (state != S_FLUSH);
   assign STATE_DBG = state;

   // Control FSM and the two-entry buffer; flush discards everything at once.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state      <= S_IDLE;
         M_VALID    <= 1'b0;
         M_DATA     <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         in_flight  <= 1'b0;
      end else if (FLUSH) begin
         state      <= S_FLUSH;
         M_VALID    <= 1'b0;
         skid_valid <= 1'b0;
         in_flight  <= 1'b0;
      end else begin
         case (state)
            S_IDLE:  if (ENABLE)  state <= S_RUN;
            S_RUN:   if (!ENABLE) state <= S_IDLE;
            S_FLUSH: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase

         in_flight <= READ;

         // Words already buffered or in flight keep draining in every state.
         if (xfer) begin
            if (skid_valid) begin
               M_DATA     <= skid_data;
               M_VALID    <= 1'b1;
               skid_valid <= in_flight;
               if (in_flight) skid_data <= FIFO_DATA;
            end else if (in_flight) begin
               M_DATA  <= FIFO_DATA;
               M_VALID <= 1'b1;
            end else begin
               M_VALID <= 1'b0;
            end
         end else if (in_flight) begin
            if (!M_VALID) begin
               M_DATA  <= FIFO_DATA;
               M_VALID <= 1'b1;
            end else begin
               skid_data  <= FIFO_DATA;
               skid_valid <= 1'b1;
            end
         end
      end
   end

`ifdef FIFO_READER_COUNT_EN
   logic [15:0] word_cnt;

   // Count accepted downstream words, wrapping naturally at 16 bits.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET)      word_cnt <= 16'd0;
      else if (FLUSH) word_cnt <= 16'd0;
      else if (xfer)  word_cnt <= word_cnt + 16'd1;
   end

   assign WORD_COUNT = word_cnt;
`else
   assign WORD_COUNT = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed bench for fifo_reader with a behavioural FIFO whose
// USE_DW / F_EMPTY_N flags lag a read by one cycle (as a registered-flag FIFO).
module tb_fifo_reader;

   localparam int SIZE = 8;
   localparam int TAM  = 32;
   localparam int DW   = $clog2(TAM-1);
`ifdef FIFO_READER_COUNT_EN
   localparam bit COUNT_EN = 1'b1;
`else
   localparam bit COUNT_EN = 1'b0;
`endif

   logic            CLOCK = 1'b0;
   logic            RESET;
   logic            ENABLE;
   logic            FLUSH;
   logic            F_EMPTY_N;
   logic [DW-1:0]   USE_DW;
   logic [SIZE-1:0] FIFO_DATA;
   logic            READ;
   logic            CLEAR_N;
   logic [SIZE-1:0] M_DATA;
   logic            M_VALID;
   logic            M_READY;
   logic [15:0]     WORD_COUNT;
   logic [1:0]      STATE_DBG;

   int tests  = 0;
   int errors = 0;

   fifo_reader #(.size(SIZE), .tam(TAM)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .ENABLE(ENABLE), .FLUSH(FLUSH),
      .F_EMPTY_N(F_EMPTY_N), .USE_DW(USE_DW), .FIFO_DATA(FIFO_DATA),
      .READ(READ), .CLEAR_N(CLEAR_N), .M_DATA(M_DATA), .M_VALID(M_VALID),
      .M_READY(M_READY), .WORD_COUNT(WORD_COUNT), .STATE_DBG(STATE_DBG)
   );

   // ---------------- clock ----------------
   initial forever #5 CLOCK = ~CLOCK;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- FIFO model ----------------
   logic [SIZE-1:0] push_buf[256];
   int              push_wr = 0;
   int              push_rd = 0;
   logic [SIZE-1:0] fifo_q[$];
   logic [DW-1:0]   usedw = '0;
   logic [SIZE-1:0] fifo_data = '0;
   bit              over_read = 1'b0;
   int              outstanding = 0;
   int              max_fill = 0;

   assign F_EMPTY_N = (usedw != '0);
   assign USE_DW    = usedw;
   assign FIFO_DATA = fifo_data;

   // FIFO behaviour plus tracking of words popped but not yet accepted.
   always @(posedge CLOCK) begin
      while (push_rd != push_wr) begin
         fifo_q.push_back(push_buf[push_rd]);
         push_rd++;
      end
      if (!CLEAR_N) begin
         fifo_q.delete();
         usedw <= '0;
      end else begin
         usedw <= DW'(fifo_q.size());
         if (READ) begin
            if (fifo_q.size() == 0) over_read = 1'b1;
            else fifo_data <= fifo_q.pop_front();
         end
      end
      if (RESET || FLUSH) outstanding = 0;
      else outstanding = outstanding + ((READ && CLEAR_N) ? 1 : 0) - ((M_VALID && M_READY) ? 1 : 0);
      if (outstanding > max_fill) max_fill = outstanding;
   end

   // ---------------- scoreboard ----------------
   logic [SIZE-1:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic push(input logic [SIZE-1:0] d, input bit expect_it);
      push_buf[push_wr] = d;
      push_wr++;
      if (expect_it) exp_q.push_back(d);
   endtask

   typedef struct {
      logic            en;
      logic            rdy;
      logic            fl;
      logic            e_read;
      logic            e_valid;
      logic [SIZE-1:0] e_data;
      logic            e_clear_n;
      logic [1:0]      e_state;
   } vec_t;

   function automatic vec_t mk(input logic en, rdy, fl, rd, v, input logic [SIZE-1:0] d,
                               input logic cn, input logic [1:0] st);
      vec_t r;
      r.en = en; r.rdy = rdy; r.fl = fl; r.e_read = rd; r.e_valid = v;
      r.e_data = d; r.e_clear_n = cn; r.e_state = st;
      return r;
   endfunction

   task automatic apply_vec(input vec_t v, input string tag);
      @(negedge CLOCK);
      ENABLE  = v.en;
      M_READY = v.rdy;
      FLUSH   = v.fl;
      #1;
      chk({tag, ".read"},    READ,      v.e_read);
      chk({tag, ".valid"},   M_VALID,   v.e_valid);
      if (v.e_valid) chk({tag, ".data"}, M_DATA, v.e_data);
      chk({tag, ".clear_n"}, CLEAR_N,   v.e_clear_n);
      chk({tag, ".state"},   STATE_DBG, v.e_state);
   endtask

   // Run the stream until 'target' words are accepted; with bp set, M_READY
   // follows 1,0,0,1,... and stalled words must hold.
   task automatic drain(input int target, input bit bp, input int budget, input string tag);
      int              got = 0;
      int              cyc = 0;
      bit              pv = 1'b0;
      bit              pr = 1'b0;
      logic [SIZE-1:0] pd = '0;
      logic [SIZE-1:0] e;
      logic [3:0]      pat = 4'b1001;
      while (got < target && cyc < budget) begin
         @(negedge CLOCK);
         M_READY = bp ? pat[2'(cyc % 4)] : 1'b1;
         #1;
         if (pv && !pr) begin
            chk({tag, ".hold_valid"}, M_VALID, 1'b1);
            chk({tag, ".hold_data"},  M_DATA,  pd);
         end
         if (M_VALID && M_READY) begin
            if (exp_q.size() == 0) begin
               chk({tag, ".extra_word"}, M_DATA, 32'hDEAD);
            end else begin
               e = exp_q.pop_front();
               chk({tag, ".data"}, M_DATA, e);
            end
            got++;
         end
         pv = M_VALID; pr = M_READY; pd = M_DATA;
         cyc++;
      end
      if (got < target) chk({tag, ".timeout"}, got, target);
   endtask

   vec_t stream_v[14];
   vec_t flush_v[6];
   int   n_rest;

   // ---------------- test sequence ----------------
   initial begin
      RESET = 1'b1; ENABLE = 1'b0; FLUSH = 1'b0; M_READY = 1'b0;

      // Streaming: enable at row 0, READ from row 1, first word visible at
      // row 3, then one word per cycle; the tenth word's read is the last.
      for (int k = 0; k < 14; k++)
         stream_v[k] = mk(1'b1, 1'b1, 1'b0, (k >= 1 && k <= 10), (k >= 3 && k <= 12),
                          SIZE'(k - 2), 1'b1, (k == 0) ? 2'd0 : 2'd1);

      // Flush with one word buffered and one in flight, backpressure held.
      flush_v[0] = mk(1, 0, 0, 1, 0, 8'h00, 1, 2'd1);
      flush_v[1] = mk(1, 0, 0, 1, 0, 8'h00, 1, 2'd1);
      flush_v[2] = mk(1, 0, 1, 0, 1, 8'h31, 1, 2'd1);
      flush_v[3] = mk(1, 0, 0, 0, 0, 8'h00, 0, 2'd2);
      flush_v[4] = mk(1, 0, 0, 0, 0, 8'h00, 1, 2'd0);
      flush_v[5] = mk(1, 0, 0, 0, 0, 8'h00, 1, 2'd1);

      for (int d = 1; d <= 10; d++) push(SIZE'(d), 1'b0);

      // Reset values
      repeat (3) @(negedge CLOCK);
      #1;
      chk("reset.read",    READ,       1'b0);
      chk("reset.clear_n", CLEAR_N,    1'b1);
      chk("reset.valid",   M_VALID,    1'b0);
      chk("reset.data",    M_DATA,     8'h00);
      chk("reset.count",   WORD_COUNT, 16'h0000);
      chk("reset.state",   STATE_DBG,  2'd0);
      @(negedge CLOCK);
      RESET = 1'b0;

      // Streaming table
      for (int i = 0; i < 14; i++) apply_vec(stream_v[i], $sformatf("stream[%0d]", i));
      chk("stream.count", WORD_COUNT, COUNT_EN ? 16'd10 : 16'd0);

      // Last word: a read in flight with USE_DW=1 must not trigger another
      @(negedge CLOCK);
      push(8'h21, 1'b0);
      ENABLE = 1'b1; M_READY = 1'b1;
      #1 chk("last.read_before_flags", READ, 1'b0);
      @(negedge CLOCK); #1 chk("last.read", READ, 1'b1);
      @(negedge CLOCK); #1 chk("last.no_second_read", READ, 1'b0);
      @(negedge CLOCK); #1;
      chk("last.valid", M_VALID, 1'b1);
      chk("last.data",  M_DATA,  8'h21);
      chk("last.read_after", READ, 1'b0);
      @(negedge CLOCK); #1 chk("last.valid_drop", M_VALID, 1'b0);

      // Backpressure
      @(negedge CLOCK);
      for (int d = 8'h11; d <= 8'h15; d++) push(SIZE'(d), 1'b1);
      drain(5, 1'b1, 60, "bp");
      chk("bp.fill_over_2", 32'(max_fill > 2), 0);

      // Flush
      @(negedge CLOCK);
      M_READY = 1'b0;
      for (int d = 8'h31; d <= 8'h35; d++) push(SIZE'(d), 1'b0);
      for (int i = 0; i < 6; i++) apply_vec(flush_v[i], $sformatf("flush[%0d]", i));
      chk("flush.count", WORD_COUNT, 16'h0000);
      @(negedge CLOCK);
      push(8'h41, 1'b1);
      push(8'h42, 1'b1);
      drain(2, 1'b0, 20, "post_flush");
      @(negedge CLOCK); #1 chk("post_flush.idle", M_VALID, 1'b0);

      // Reset in the middle of a burst
      @(negedge CLOCK);
      for (int d = 8'h51; d <= 8'h5A; d++) push(SIZE'(d), 1'b1);
      drain(3, 1'b0, 30, "rst_burst");
      @(negedge CLOCK);
      RESET = 1'b1;
      #1;
      chk("rst.read",    READ,       1'b0);
      chk("rst.clear_n", CLEAR_N,    1'b1);
      chk("rst.valid",   M_VALID,    1'b0);
      chk("rst.data",    M_DATA,     8'h00);
      chk("rst.count",   WORD_COUNT, 16'h0000);
      chk("rst.state",   STATE_DBG,  2'd0);
      @(negedge CLOCK);
      RESET = 1'b0; ENABLE = 1'b0;
      #1 chk("rst.idle_read0", READ, 1'b0);
      @(negedge CLOCK); #1;
      chk("rst.idle_read1", READ, 1'b0);
      chk("rst.idle_valid", M_VALID, 1'b0);
      exp_q.delete();
      foreach (fifo_q[k]) exp_q.push_back(fifo_q[k]);
      n_rest = exp_q.size();
      @(negedge CLOCK);
      ENABLE = 1'b1;
      drain(n_rest, 1'b0, 40, "rst_resume");
      @(negedge CLOCK); #1 chk("rst_resume.count", WORD_COUNT, COUNT_EN ? 16'(n_rest) : 16'd0);

      // Counter wrap
      @(negedge CLOCK);
`ifdef FIFO_READER_COUNT_EN
      force dut.word_cnt = 16'hFFFE;
      @(negedge CLOCK);
      release dut.word_cnt;
`endif
      for (int d = 8'h61; d <= 8'h63; d++) push(SIZE'(d), 1'b1);
      drain(3, 1'b0, 20, "wrap");
      @(negedge CLOCK); #1 chk("wrap.count", WORD_COUNT, COUNT_EN ? 16'h0001 : 16'h0000);

      chk("fifo.over_read", over_read, 1'b0);
      chk("final.fill_over_2", 32'(max_fill > 2), 0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
